// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
// vrf_pkg : shared widths and write-request type for the vector register file
// Rev 1.0
// ============================================================================
package vrf_pkg;
   localparam int VRF_DATA_W       = 32;
   localparam int VRF_IDX_W        = 10;
   localparam int VRF_NUM_WR_PORTS = 2;

   // index[4:0] selects the register, index[9:5] the element
   typedef struct packed {
      logic [VRF_IDX_W-1:0]  index;
      logic [VRF_DATA_W-1:0] msg;
   } vrf_wr_req_t;
endpackage
`default_nettype wire

// File: rtl/vrf_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// vrf_write_scheduler_if : producer request port and dual RF write ports
// Optional conflict_cnt when VRF_WSCHED_STATS_EN is defined.  Rev 1.0
// ============================================================================
interface vrf_write_scheduler_if
   import vrf_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = VRF_DATA_W,
   parameter int IDX_W  = VRF_IDX_W
) ();
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] recv_msg;
   logic [IDX_W-1:0]  recv_index;
   logic              recv_val;
   logic              recv_rdy;
   logic [DATA_W-1:0] send_msg_0;
   logic [DATA_W-1:0] send_msg_1;
   logic [IDX_W-1:0]  send_index_0;
   logic [IDX_W-1:0]  send_index_1;
   logic              send_val_0;
   logic              send_val_1;
   logic              send_rdy_0;
   logic              send_rdy_1;
   logic [CNT_W-1:0]  occupancy;
`ifdef VRF_WSCHED_STATS_EN
   logic [15:0]       conflict_cnt;
`endif

   modport slave (
      input  recv_msg, recv_index, recv_val, send_rdy_0, send_rdy_1,
      output recv_rdy, send_msg_0, send_msg_1, send_index_0, send_index_1,
             send_val_0, send_val_1, occupancy
`ifdef VRF_WSCHED_STATS_EN
      , output conflict_cnt
`endif
   );

   modport master (
      output recv_msg, recv_index, recv_val, send_rdy_0, send_rdy_1,
      input  recv_rdy, send_msg_0, send_msg_1, send_index_0, send_index_1,
             send_val_0, send_val_1, occupancy
`ifdef VRF_WSCHED_STATS_EN
      , input conflict_cnt
`endif
   );
endinterface
`default_nettype wire

// File: rtl/vrf_wr_fifo.sv
`default_nettype none
// ============================================================================
// vrf_wr_fifo : in-order write buffer exposing head and head+1, pop by 0/1/2
// Rev 1.0
// ============================================================================
module vrf_wr_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [IDX_W-1:0]         push_idx_i,
   input  logic [DATA_W-1:0]        push_msg_i,
   input  logic [1:0]               pop_i,
   output logic [IDX_W-1:0]         head0_idx_o,
   output logic [DATA_W-1:0]        head0_msg_o,
   output logic [IDX_W-1:0]         head1_idx_o,
   output logic [DATA_W-1:0]        head1_msg_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0]  idx_mem_q [DEPTH];
   logic [DATA_W-1:0] msg_mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, w_head1;
   logic [CNT_W-1:0]  count_q, count_d;

   // Power-of-two depth: pointer arithmetic wraps naturally by truncation
   always_comb begin
      head_d  = head_q + PTR_W'(pop_i);
      tail_d  = tail_q + PTR_W'(push_i);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         idx_mem_q[tail_q] <= push_idx_i;
         msg_mem_q[tail_q] <= push_msg_i;
      end
   end

   assign w_head1     = head_q + PTR_W'(1);
   assign head0_idx_o = idx_mem_q[head_q];
   assign head0_msg_o = msg_mem_q[head_q];
   assign head1_idx_o = idx_mem_q[w_head1];
   assign head1_msg_o = msg_mem_q[w_head1];
   assign count_o     = count_q;
endmodule
`default_nettype wire

// File: rtl/vrf_write_scheduler.sv
`default_nettype none
// ============================================================================
// vrf_write_scheduler : buffers write requests and drains up to two per cycle
// Optional stats via VRF_WSCHED_STATS_EN.  Rev 1.0
// ============================================================================
module vrf_write_scheduler
   import vrf_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = VRF_DATA_W,
   parameter int IDX_W  = VRF_IDX_W
) (
   input  logic                  clk,
   input  logic                  reset,
   vrf_write_scheduler_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0]  w_count;
   logic [IDX_W-1:0]  w_h0_idx, w_h1_idx;
   logic [DATA_W-1:0] w_h0_msg, w_h1_msg;
   logic              rdy_en_q;
   logic              w_push, w_val0, w_val1, w_same_idx, w_fire0, w_fire1;
   logic [1:0]        w_pop;

   vrf_wr_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (w_push),
      .push_idx_i  (bus.recv_index),
      .push_msg_i  (bus.recv_msg),
      .pop_i       (w_pop),
      .head0_idx_o (w_h0_idx),
      .head0_msg_o (w_h0_msg),
      .head1_idx_o (w_h1_idx),
      .head1_msg_o (w_h1_msg),
      .count_o     (w_count)
   );

   // Keeps recv_rdy low while reset is held; rises on the first clock after release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdy_en_q <= 1'b0;
      else        rdy_en_q <= 1'b1;
   end

   assign bus.recv_rdy = rdy_en_q && (w_count < CNT_W'(DEPTH));
   assign w_push       = bus.recv_val && bus.recv_rdy;

   assign w_same_idx = (w_count >= CNT_W'(2)) && (w_h0_idx == w_h1_idx);
   assign w_val0     = (w_count != '0);
   assign w_val1     = (w_count >= CNT_W'(2)) && !w_same_idx && bus.send_rdy_0;
   assign w_fire0    = w_val0 && bus.send_rdy_0;
   assign w_fire1    = w_val1 && bus.send_rdy_1;
   assign w_pop      = {1'b0, w_fire0} + {1'b0, w_fire1};

   assign bus.send_val_0   = w_val0;
   assign bus.send_val_1   = w_val1;
   assign bus.send_msg_0   = w_val0 ? w_h0_msg : '0;
   assign bus.send_index_0 = w_val0 ? w_h0_idx : '0;
   assign bus.send_msg_1   = w_val1 ? w_h1_msg : '0;
   assign bus.send_index_1 = w_val1 ? w_h1_idx : '0;
   assign bus.occupancy    = w_count;

`ifdef VRF_WSCHED_STATS_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (w_same_idx && bus.send_rdy_0 && (conflict_cnt_q != 16'hFFFF))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) conflict_cnt_q <= '0;
      else        conflict_cnt_q <= conflict_cnt_d;
   end

   assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vrf_write_scheduler.sv
`default_nettype none
// ============================================================================
// tb_vrf_write_scheduler : directed self-checking bench for vrf_write_scheduler
// Rev 1.0
// ============================================================================
module tb_vrf_write_scheduler;
   import vrf_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   vrf_write_scheduler_if #(.DEPTH(8), .DATA_W(32), .IDX_W(10)) bus ();

   vrf_write_scheduler #(.DEPTH(8), .DATA_W(32), .IDX_W(10)) dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vrf_wr_req_t q[$];
   int          k;
   int          npop;
   logic        exp_rdy, exp_v0, exp_v1;

   initial begin
      reset_n         = 1'b0;
      bus.recv_val    = 1'b1;
      bus.recv_index  = 10'h3FF;
      bus.recv_msg    = 32'h1234_5678;
      bus.send_rdy_0  = 1'b0;
      bus.send_rdy_1  = 1'b0;

      // Reset held with a pending request
      tick(); tick();
      check("rst_recv_rdy", bus.recv_rdy, 1'b0);
      check("rst_val0", bus.send_val_0, 1'b0);
      check("rst_val1", bus.send_val_1, 1'b0);
      check("rst_occ", bus.occupancy, 4'd0);
      check("rst_msg0", bus.send_msg_0, 32'h0);
      reset_n      = 1'b1;
      bus.recv_val = 1'b0;
      tick();
      check("rel_recv_rdy", bus.recv_rdy, 1'b1);
      check("rel_occ", bus.occupancy, 4'd0);

      // Single write, one-cycle latency
      bus.send_rdy_0 = 1'b1;
      bus.send_rdy_1 = 1'b1;
      bus.recv_val   = 1'b1;
      bus.recv_index = 10'h021;
      bus.recv_msg   = 32'hDEAD_BEEF;
      tick();
      bus.recv_val = 1'b0;
      check("single_val0", bus.send_val_0, 1'b1);
      check("single_idx0", bus.send_index_0, 10'h021);
      check("single_msg0", bus.send_msg_0, 32'hDEAD_BEEF);
      check("single_val1", bus.send_val_1, 1'b0);
      check("single_idx1_zero", bus.send_index_1, 10'h0);
      check("single_occ", bus.occupancy, 4'd1);
      tick();
      check("single_empty_val0", bus.send_val_0, 1'b0);
      check("single_empty_occ", bus.occupancy, 4'd0);
      check("single_empty_msg0", bus.send_msg_0, 32'h0);

      // Dual drain
      bus.send_rdy_0 = 1'b0;
      bus.send_rdy_1 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         bus.recv_val   = 1'b1;
         bus.recv_index = 10'(i);
         bus.recv_msg   = 32'h100 + 32'(i);
         tick();
      end
      bus.recv_val = 1'b0;
      check("dual_occ4", bus.occupancy, 4'd4);
      check("dual_val0_held", bus.send_val_0, 1'b1);
      check("dual_val1_rdy0low", bus.send_val_1, 1'b0);
      bus.send_rdy_0 = 1'b1;
      bus.send_rdy_1 = 1'b1;
      #1;
      check("dual_c1_idx0", bus.send_index_0, 10'd1);
      check("dual_c1_val1", bus.send_val_1, 1'b1);
      check("dual_c1_idx1", bus.send_index_1, 10'd2);
      check("dual_c1_msg1", bus.send_msg_1, 32'h102);
      tick();
      check("dual_occ2", bus.occupancy, 4'd2);
      check("dual_c2_idx0", bus.send_index_0, 10'd3);
      check("dual_c2_idx1", bus.send_index_1, 10'd4);
      tick();
      check("dual_occ0", bus.occupancy, 4'd0);
      check("dual_done_val0", bus.send_val_0, 1'b0);

      // Index conflict
      bus.send_rdy_0 = 1'b0;
      bus.send_rdy_1 = 1'b0;
      bus.recv_val   = 1'b1;
      bus.recv_index = 10'd5;
      bus.recv_msg   = 32'hAAAA_0001;
      tick();
      bus.recv_msg   = 32'hBBBB_0002;
      tick();
      bus.recv_val   = 1'b0;
      bus.send_rdy_0 = 1'b1;
      bus.send_rdy_1 = 1'b1;
      #1;
      check("conf_val0", bus.send_val_0, 1'b1);
      check("conf_msg0_A", bus.send_msg_0, 32'hAAAA_0001);
      check("conf_val1", bus.send_val_1, 1'b0);
      check("conf_msg1_zero", bus.send_msg_1, 32'h0);
      tick();
      check("conf_occ1", bus.occupancy, 4'd1);
      check("conf_msg0_B", bus.send_msg_0, 32'hBBBB_0002);
      tick();
      check("conf_occ0", bus.occupancy, 4'd0);
`ifdef VRF_WSCHED_STATS_EN
      check("conf_cnt", bus.conflict_cnt, 16'd1);
`endif

      // Full, then drain two per cycle while pushing across pointer wrap
      bus.send_rdy_0 = 1'b0;
      bus.send_rdy_1 = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         bus.recv_val   = 1'b1;
         bus.recv_index = 10'(k);
         bus.recv_msg   = 32'hC000_0000 + 32'(k);
         tick();
         q.push_back(vrf_wr_req_t'{index: 10'(k), msg: 32'hC000_0000 + 32'(k)});
         k++;
      end
      bus.recv_index = 10'(k);
      bus.recv_msg   = 32'hC000_0000 + 32'(k);
      #1;
      check("full_occ8", bus.occupancy, 4'd8);
      check("full_recv_rdy", bus.recv_rdy, 1'b0);
      tick();
      check("full_held_occ", bus.occupancy, 4'd8);
      check("full_held_idx0", bus.send_index_0, 10'd0);
      bus.send_rdy_0 = 1'b1;
      bus.send_rdy_1 = 1'b1;
      #1;
      for (int cyc = 0; cyc < 100 && (k < 32 || q.size() != 0); cyc++) begin
         exp_rdy = (q.size() < 8);
         exp_v0  = (q.size() >= 1);
         exp_v1  = (q.size() >= 2) && (q[0].index != q[1].index);
         check("wrap_recv_rdy", bus.recv_rdy, exp_rdy);
         check("wrap_val0", bus.send_val_0, exp_v0);
         check("wrap_val1", bus.send_val_1, exp_v1);
         if (exp_v0) check("wrap_msg0", bus.send_msg_0, q[0].msg);
         if (exp_v1) check("wrap_msg1", bus.send_msg_1, q[1].msg);
         npop = int'(exp_v0) + int'(exp_v1);
         for (int p = 0; p < npop; p++) void'(q.pop_front());
         if (bus.recv_val && exp_rdy) begin
            q.push_back(vrf_wr_req_t'{index: 10'(k), msg: 32'hC000_0000 + 32'(k)});
            k++;
         end
         tick();
         bus.recv_val   = (k < 32);
         bus.recv_index = 10'(k);
         bus.recv_msg   = 32'hC000_0000 + 32'(k);
         #1;
      end
      check("wrap_all_pushed", 64'(k), 64'd32);
      check("wrap_model_empty", 64'(q.size()), 64'd0);
      check("wrap_occ0", bus.occupancy, 4'd0);

      // Backpressure on port 0 blocks port 1, then reset mid-stream
      bus.send_rdy_0 = 1'b0;
      bus.send_rdy_1 = 1'b0;
      for (int i = 7; i <= 9; i++) begin
         bus.recv_val   = 1'b1;
         bus.recv_index = 10'(i);
         bus.recv_msg   = 32'h700 + 32'(i);
         tick();
      end
      bus.recv_val   = 1'b0;
      bus.send_rdy_1 = 1'b1;
      #1;
      check("bp_occ3", bus.occupancy, 4'd3);
      check("bp_val0", bus.send_val_0, 1'b1);
      check("bp_val1", bus.send_val_1, 1'b0);
      tick();
      check("bp_occ_hold", bus.occupancy, 4'd3);
      check("bp_idx0", bus.send_index_0, 10'd7);
      reset_n = 1'b0;
      #1;
      check("midrst_occ", bus.occupancy, 4'd0);
      check("midrst_val0", bus.send_val_0, 1'b0);
      check("midrst_recv_rdy", bus.recv_rdy, 1'b0);
`ifdef VRF_WSCHED_STATS_EN
      check("midrst_cnt", bus.conflict_cnt, 16'd0);
`endif
      reset_n = 1'b1;
      tick();
      check("post_rst_recv_rdy", bus.recv_rdy, 1'b1);
      check("post_rst_occ", bus.occupancy, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
